// File: rtl/recir_ctrl.sv
// Recirculation-stage link controller: acquires COM symbol lock, qualifies the
// link as active, and steers the four receive lanes to the mux or tester path.
module recir_ctrl #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic       clk4f,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] valid_in,
    output logic       active,
    output logic [7:0] out0m,
    output logic [7:0] out1m,
    output logic [7:0] out2m,
    output logic [7:0] out3m,
    output logic [3:0] valid_outm,
    output logic [7:0] out0t,
    output logic [7:0] out1t,
    output logic [7:0] out2t,
    output logic [7:0] out3t,
    output logic [3:0] valid_outt,
    output logic [1:0] state_o,
    output logic [7:0] lock_cnt
);

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned COM_W  = 3;
    localparam int unsigned LOSS_W = 4;
    localparam int unsigned LOCK_W = 8;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_SEARCH = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [COM_W-1:0]                com_cnt_q, com_cnt_d;
    logic [LOSS_W-1:0]               loss_cnt_q, loss_cnt_d;
    logic [LOCK_W-1:0]               lock_cnt_q, lock_cnt_d;
    logic                            active_q, active_d;
    logic [LANES-1:0][DATA_W-1:0]    lanes_c;
    logic [LANES-1:0][DATA_W-1:0]    mux_q, mux_d;
    logic [LANES-1:0][DATA_W-1:0]    tst_q, tst_d;
    logic [LANES-1:0]                vm_q, vm_d;
    logic [LANES-1:0]                vt_q, vt_d;

    assign lanes_c = {in3, in2, in1, in0};

    // State, counters and all outputs share one register bank
    always_ff @(posedge clk4f or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RESET;
            com_cnt_q  <= '0;
            loss_cnt_q <= '0;
            lock_cnt_q <= '0;
            active_q   <= 1'b0;
            mux_q      <= '0;
            tst_q      <= '0;
            vm_q       <= '0;
            vt_q       <= '0;
        end else begin
            state_q    <= state_d;
            com_cnt_q  <= com_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            active_q   <= active_d;
            mux_q      <= mux_d;
            tst_q      <= tst_d;
            vm_q       <= vm_d;
            vt_q       <= vt_d;
        end
    end

    // Next-state, counter and lane-steering logic keyed on the current state
    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        loss_cnt_d = loss_cnt_q;
        lock_cnt_d = lock_cnt_q;
        mux_d      = '0;
        tst_d      = '0;
        vm_d       = '0;
        vt_d       = '0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                tst_d = lanes_c;
                vt_d  = valid_in;
                if (rx_valid) begin
                    if (rx_byte == COM) begin
                        if (com_cnt_q == COM_W'(LOCK_COUNT - 1)) begin
                            state_d    = ST_ACTIVE;
                            com_cnt_d  = '0;
                            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                        end else begin
                            com_cnt_d = com_cnt_q + COM_W'(1);
                        end
                    end else begin
                        com_cnt_d = '0;
                    end
                end
            end
            ST_ACTIVE: begin
                mux_d = lanes_c;
                vm_d  = valid_in;
                if (rx_valid) begin
                    loss_cnt_d = '0;
                end else if (loss_cnt_q == LOSS_W'(LOSS_COUNT - 1)) begin
                    state_d    = ST_DRAIN;
                    loss_cnt_d = '0;
                end else begin
                    loss_cnt_d = loss_cnt_q + LOSS_W'(1);
                end
            end
            ST_DRAIN: begin
                state_d   = ST_SEARCH;
                com_cnt_d = '0;
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        active_d = (state_d == ST_ACTIVE);
    end

    assign active     = active_q;
    assign state_o    = state_q;
    assign lock_cnt   = lock_cnt_q;
    assign out0m      = mux_q[0];
    assign out1m      = mux_q[1];
    assign out2m      = mux_q[2];
    assign out3m      = mux_q[3];
    assign valid_outm = vm_q;
    assign out0t      = tst_q[0];
    assign out1t      = tst_q[1];
    assign out2t      = tst_q[2];
    assign out3t      = tst_q[3];
    assign valid_outt = vt_q;

endmodule
